// File: rtl/jelly3_axi4l_arbiter_pkg.sv
// Shared types for the AXI4-Lite N:1 arbiter: write/read FSM states and
// the grant-index width helper used by the top and the round-robin selector.
package jelly3_axi4l_arbiter_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // A single-master build still carries a 1-bit grant register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jelly3_axi4l_if.sv
// AXI4-Lite bundle; modport s faces an upstream master, modport m drives
// a downstream slave.
interface jelly3_axi4l_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport s (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport m (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/jelly3_rr_select.sv
// Combinational round-robin pick: first requesting index strictly after
// 'last', wrapping to the lowest requester when none lies above it.
module jelly3_rr_select
    import jelly3_axi4l_arbiter_pkg::*;
#(
    parameter int NUM = 2,
    parameter int IW  = idx_width(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [IW-1:0]  gnt,
    output logic           valid
);

    logic [IW-1:0] lo_idx;
    logic [IW-1:0] hi_idx;
    logic          hi_hit;

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_hit = 1'b0;
        valid  = 1'b0;
        for (int j = NUM - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_idx = IW'(j);
                valid  = 1'b1;
                if (j > int'(last)) begin
                    hi_idx = IW'(j);
                    hi_hit = 1'b1;
                end
            end
        end
    end

    assign gnt = hi_hit ? hi_idx : lo_idx;

endmodule

// File: rtl/jelly3_axi4l_arbiter.sv
// N:1 AXI4-Lite arbiter with independent round-robin write and read paths,
// one outstanding transaction per path, combinational pass-through after grant.
//
// state  | meaning
// W_IDLE | no write owned; grant taken on any awvalid
// W_XFER | AW and W of wgnt forwarded until each has handshaken once
// W_RESP | B routed between downstream and wgnt
// R_IDLE | no read owned; grant taken on any arvalid
// R_ADDR | AR of rgnt forwarded until its handshake
// R_DATA | R routed between downstream and rgnt
module jelly3_axi4l_arbiter
    import jelly3_axi4l_arbiter_pkg::*;
#(
    parameter int NUM        = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic      aresetn,
    input  logic      aclk,
    jelly3_axi4l_if.s s_axi4l [0:NUM-1],
    jelly3_axi4l_if.m m_axi4l
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IW         = idx_width(NUM);
    localparam int NSLOT      = 1 << IW;

    logic [ADDR_WIDTH-1:0] s_awaddr [NSLOT];
    logic [2:0]            s_awprot [NSLOT];
    logic [DATA_WIDTH-1:0] s_wdata  [NSLOT];
    logic [STRB_WIDTH-1:0] s_wstrb  [NSLOT];
    logic [ADDR_WIDTH-1:0] s_araddr [NSLOT];
    logic [2:0]            s_arprot [NSLOT];
    logic [NSLOT-1:0]      s_awvalid;
    logic [NSLOT-1:0]      s_wvalid;
    logic [NSLOT-1:0]      s_bready;
    logic [NSLOT-1:0]      s_arvalid;
    logic [NSLOT-1:0]      s_rready;

    wstate_t       wstate, wstate_next;
    rstate_t       rstate, rstate_next;
    logic          aw_done, aw_done_next;
    logic          w_done, w_done_next;
    logic [IW-1:0] wgnt, rgnt;
    logic [IW-1:0] wsel, rsel;
    logic          wsel_valid, rsel_valid;
    logic          wgrant, rgrant;

    logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Unpopulated slots pad the grant-indexed arrays to a power of two.
    for (genvar i = 0; i < NSLOT; i++) begin : g_port
        if (i < NUM) begin : g_used
            assign s_awaddr[i]  = s_axi4l[i].awaddr;
            assign s_awprot[i]  = s_axi4l[i].awprot;
            assign s_awvalid[i] = s_axi4l[i].awvalid;
            assign s_wdata[i]   = s_axi4l[i].wdata;
            assign s_wstrb[i]   = s_axi4l[i].wstrb;
            assign s_wvalid[i]  = s_axi4l[i].wvalid;
            assign s_bready[i]  = s_axi4l[i].bready;
            assign s_araddr[i]  = s_axi4l[i].araddr;
            assign s_arprot[i]  = s_axi4l[i].arprot;
            assign s_arvalid[i] = s_axi4l[i].arvalid;
            assign s_rready[i]  = s_axi4l[i].rready;

            assign s_axi4l[i].awready = (wgnt == IW'(i)) && (wstate == W_XFER) && !aw_done && m_axi4l.awready;
            assign s_axi4l[i].wready  = (wgnt == IW'(i)) && (wstate == W_XFER) && !w_done && m_axi4l.wready;
            assign s_axi4l[i].bvalid  = (wgnt == IW'(i)) && (wstate == W_RESP) && m_axi4l.bvalid;
            assign s_axi4l[i].bresp   = m_axi4l.bresp;
            assign s_axi4l[i].arready = (rgnt == IW'(i)) && (rstate == R_ADDR) && m_axi4l.arready;
            assign s_axi4l[i].rvalid  = (rgnt == IW'(i)) && (rstate == R_DATA) && m_axi4l.rvalid;
            assign s_axi4l[i].rdata   = m_axi4l.rdata;
            assign s_axi4l[i].rresp   = m_axi4l.rresp;
        end else begin : g_pad
            assign s_awaddr[i]  = '0;
            assign s_awprot[i]  = '0;
            assign s_awvalid[i] = 1'b0;
            assign s_wdata[i]   = '0;
            assign s_wstrb[i]   = '0;
            assign s_wvalid[i]  = 1'b0;
            assign s_bready[i]  = 1'b0;
            assign s_araddr[i]  = '0;
            assign s_arprot[i]  = '0;
            assign s_arvalid[i] = 1'b0;
            assign s_rready[i]  = 1'b0;
        end
    end

    // The held grant doubles as the last-grant pointer.
    jelly3_rr_select #(.NUM(NUM), .IW(IW)) u_wsel (
        .req   (s_awvalid[NUM-1:0]),
        .last  (wgnt),
        .gnt   (wsel),
        .valid (wsel_valid)
    );

    jelly3_rr_select #(.NUM(NUM), .IW(IW)) u_rsel (
        .req   (s_arvalid[NUM-1:0]),
        .last  (rgnt),
        .gnt   (rsel),
        .valid (rsel_valid)
    );

    assign m_awvalid = (wstate == W_XFER) && s_awvalid[wgnt] && !aw_done;
    assign m_wvalid  = (wstate == W_XFER) && s_wvalid[wgnt] && !w_done;
    assign m_bready  = (wstate == W_RESP) && s_bready[wgnt];
    assign m_arvalid = (rstate == R_ADDR) && s_arvalid[rgnt];
    assign m_rready  = (rstate == R_DATA) && s_rready[rgnt];

    assign aw_hs = m_awvalid && m_axi4l.awready;
    assign w_hs  = m_wvalid && m_axi4l.wready;
    assign b_hs  = m_bready && m_axi4l.bvalid;
    assign ar_hs = m_arvalid && m_axi4l.arready;
    assign r_hs  = m_rready && m_axi4l.rvalid;

    assign m_axi4l.awaddr  = s_awaddr[wgnt];
    assign m_axi4l.awprot  = s_awprot[wgnt];
    assign m_axi4l.awvalid = m_awvalid;
    assign m_axi4l.wdata   = s_wdata[wgnt];
    assign m_axi4l.wstrb   = s_wstrb[wgnt];
    assign m_axi4l.wvalid  = m_wvalid;
    assign m_axi4l.bready  = m_bready;
    assign m_axi4l.araddr  = s_araddr[rgnt];
    assign m_axi4l.arprot  = s_arprot[rgnt];
    assign m_axi4l.arvalid = m_arvalid;
    assign m_axi4l.rready  = m_rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate  <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wgnt    <= IW'(NUM - 1);
            rstate  <= R_IDLE;
            rgnt    <= IW'(NUM - 1);
        end else begin
            wstate  <= wstate_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
            rstate  <= rstate_next;
            if (wgrant) wgnt <= wsel;
            if (rgrant) rgnt <= rsel;
        end
    end

    always_comb begin
        wstate_next  = wstate;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        wgrant       = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (wsel_valid) begin
                    wgrant      = 1'b1;
                    wstate_next = W_XFER;
                end
            end
            W_XFER: begin
                aw_done_next = aw_done || aw_hs;
                w_done_next  = w_done || w_hs;
                if (aw_done_next && w_done_next) wstate_next = W_RESP;
            end
            W_RESP: begin
                if (b_hs) begin
                    wstate_next  = W_IDLE;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            default: wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_next = rstate;
        rgrant      = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (rsel_valid) begin
                    rgrant      = 1'b1;
                    rstate_next = R_ADDR;
                end
            end
            R_ADDR:  if (ar_hs) rstate_next = R_DATA;
            R_DATA:  if (r_hs) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

endmodule
